// File: rtl/pipe_pkg.sv
// Shared types for the MEM->WB elastic stage: beat layout, control bundle and occupancy encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  // Writeback control bits travelling with each beat.
  typedef struct packed {
    logic MemtoReg;
    logic PCSrc;
    logic RegWrite;
  } mw_ctrl_t;

  localparam int CTRL_W = $bits(mw_ctrl_t);

  // One MEM->WB beat at the default widths. Field order matches the flat
  // vector the top builds, so the two views are interchangeable.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] ReadData;
    logic [DATA_W_DEF-1:0] ALUOut;
    logic [ADDR_W_DEF-1:0] WA3;
    mw_ctrl_t              ctrl;
  } mw_beat_t;

  // Buffer occupancy; head valid = !EMPTY, skid valid = FULL.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_mw_elastic_skid_buf2.sv
// skid_buf2: generic two-entry (head + skid) valid/ready buffer with synchronous flush.
// Latency: 1 cycle from accept to out_valid when empty; 1 beat/cycle with out_ready held high.
// Backpressure: in_ready = !skid_valid & !reset (registered state only, never out_ready).
// Ports: clk, reset (sync active-high), flush; in_valid/in_ready/in_data; out_valid/out_ready/out_data.
module skid_buf2
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occ_t         r_state;
  occ_t         w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;

  logic w_accept;
  logic w_pop;
  logic w_load_head;
  logic w_load_skid;
  logic w_skid_to_head;

  assign in_ready  = (r_state != FULL) & ~reset;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_head;

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_head    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_head = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_load_head = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && !w_pop) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (w_accept && w_pop) begin
          // Pass-through: the incoming beat replaces the one leaving.
          w_load_head = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_state_nxt    = ONE;
          w_skid_to_head = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Flush drops everything, including a beat accepted this cycle; data
    // registers keep their stale contents.
    if (flush) begin
      w_state_nxt    = EMPTY;
      w_load_head    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_head = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_head) begin
        r_head <= in_data;
      end else if (w_skid_to_head) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_mw_elastic.sv
// pipe_mw_elastic: elastic MEM->WB pipeline stage with validity-gated control and a forwarding match.
// Latency: 1 cycle accept->out_valid when empty; 1 beat/cycle when out_ready is high.
// Backpressure: two-entry skid buffer; in_ready depends only on registered state, never on out_ready.
// Ports: clk/reset/flush; MEM side in_valid/in_ready, RDM, ALUOutM, WA3M, MemtoRegM/PCSrcM/RegWriteM;
//        WB side out_valid/out_ready, ReadDataW, ALUOutW, WA3W, MemtoRegW/PCSrcW/RegWriteW;
//        fwd_addr/fwd_hit. Macro PIPE_MW_PERF_EN adds stall_cnt/bubble_cnt (saturating, cleared by reset only).
module pipe_mw_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] RDM,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [ADDR_W-1:0] WA3M,
  input  logic              MemtoRegM,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [ADDR_W-1:0] WA3W,
  output logic              MemtoRegW,
  output logic              PCSrcW,
  output logic              RegWriteW,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit
`ifdef PIPE_MW_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam int BEAT_W = 2 * DATA_W + ADDR_W + CTRL_W;

  logic [BEAT_W-1:0] w_in_beat;
  logic [BEAT_W-1:0] w_out_beat;
  mw_ctrl_t          w_in_ctrl;
  mw_ctrl_t          w_head_ctrl;

  assign w_in_ctrl = '{MemtoReg: MemtoRegM, PCSrc: PCSrcM, RegWrite: RegWriteM};
  assign w_in_beat = {RDM, ALUOutM, WA3M, w_in_ctrl};

  skid_buf2 #(
    .W (BEAT_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_beat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_beat)
  );

  // Data fields may be stale while invalid; only control is gated.
  assign ReadDataW   = w_out_beat[BEAT_W-1 -: DATA_W];
  assign ALUOutW     = w_out_beat[BEAT_W-DATA_W-1 -: DATA_W];
  assign WA3W        = w_out_beat[CTRL_W +: ADDR_W];
  assign w_head_ctrl = w_out_beat[CTRL_W-1:0];

  // A bubble must never write the register file or redirect the PC.
  assign MemtoRegW = w_head_ctrl.MemtoReg & out_valid;
  assign PCSrcW    = w_head_ctrl.PCSrc    & out_valid;
  assign RegWriteW = w_head_ctrl.RegWrite & out_valid;

  assign fwd_hit = RegWriteW & (WA3W == fwd_addr);

`ifdef PIPE_MW_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!out_valid && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_mw_elastic.sv
// Testbench for pipe_mw_elastic: directed steps then random traffic against a queue reference model.
// Latency: n/a. Backpressure: out_ready driven directly and randomly.
// Ports: none (top-level bench).
module tb_pipe_mw_elastic;
  import pipe_pkg::*;

  logic                  clk;
  logic                  reset;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W_DEF-1:0] ReadDataW;
  logic [DATA_W_DEF-1:0] ALUOutW;
  logic [ADDR_W_DEF-1:0] WA3W;
  logic                  MemtoRegW;
  logic                  PCSrcW;
  logic                  RegWriteW;
  logic [ADDR_W_DEF-1:0] fwd_addr;
  logic                  fwd_hit;
  mw_beat_t              drv;
`ifdef PIPE_MW_PERF_EN
  logic [31:0]           stall_cnt;
  logic [31:0]           bubble_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a FIFO of capacity two plus perf counters.
  mw_beat_t q[$];
  int       m_stall  = 0;
  int       m_bubble = 0;

  pipe_mw_elastic #(
    .DATA_W (DATA_W_DEF),
    .ADDR_W (ADDR_W_DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RDM       (drv.ReadData),
    .ALUOutM   (drv.ALUOut),
    .WA3M      (drv.WA3),
    .MemtoRegM (drv.ctrl.MemtoReg),
    .PCSrcM    (drv.ctrl.PCSrc),
    .RegWriteM (drv.ctrl.RegWrite),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ReadDataW (ReadDataW),
    .ALUOutW   (ALUOutW),
    .WA3W      (WA3W),
    .MemtoRegW (MemtoRegW),
    .PCSrcW    (PCSrcW),
    .RegWriteW (RegWriteW),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit)
`ifdef PIPE_MW_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against what the model predicts right now.
  task automatic check_outputs();
    bit       m_vld;
    mw_beat_t h;
    m_vld = (q.size() > 0);
    h     = m_vld ? q[0] : '0;
    chk("out_valid", out_valid, m_vld);
    chk("in_ready",  in_ready,  (q.size() < 2) && !reset);
    chk("MemtoRegW", MemtoRegW, m_vld & h.ctrl.MemtoReg);
    chk("PCSrcW",    PCSrcW,    m_vld & h.ctrl.PCSrc);
    chk("RegWriteW", RegWriteW, m_vld & h.ctrl.RegWrite);
    chk("fwd_hit",   fwd_hit,   m_vld && h.ctrl.RegWrite && (h.WA3 == fwd_addr));
    if (m_vld) begin
      chk("ReadDataW", ReadDataW, h.ReadData);
      chk("ALUOutW",   ALUOutW,   h.ALUOut);
      chk("WA3W",      WA3W,      h.WA3);
    end
`ifdef PIPE_MW_PERF_EN
    chk("stall_cnt",  stall_cnt,  m_stall);
    chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
  endtask

  // One clock: check, advance the model by the rules for this edge, land 1ns after the edge.
  task automatic step(output bit acc);
    bit       pop;
    bit       vld;
    mw_beat_t b;
    #1;
    check_outputs();
    vld = (q.size() > 0);
    acc = in_valid && (q.size() < 2) && !reset;
    pop = vld && out_ready;
    b   = drv;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (vld && !out_ready) m_stall++;
      if (!vld) m_bubble++;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(b);
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  // Offer one beat until the model says it was taken, then drop in_valid.
  task automatic send(input mw_beat_t b, input int max_cyc);
    bit a;
    a        = 1'b0;
    drv      = b;
    in_valid = 1'b1;
    for (int i = 0; i < max_cyc && !a; i++) step(a);
    chk("accept_within_budget", a, 1'b1);
    in_valid = 1'b0;
  endtask

  function automatic mw_beat_t mk(input logic [31:0] alu, input logic [3:0] wa,
                                  input logic m2r, input logic pcs, input logic rw);
    mw_beat_t b;
    b.ReadData = ~alu;
    b.ALUOut   = alu;
    b.WA3      = wa;
    b.ctrl     = '{MemtoReg: m2r, PCSrc: pcs, RegWrite: rw};
    return b;
  endfunction

  initial begin
    bit a;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fwd_addr  = '0;
    drv       = '0;

    // Reset: first edge brings state out of X, then two checked reset cycles.
    @(posedge clk);
    #1;
    idle(2);
    reset = 1'b0;
    #1;
    chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_ALUOutW",   ALUOutW,   0);
    chk("rst_WA3W",      WA3W,      0);
    chk("rst_in_ready",  in_ready,  1);

    // Streaming at full rate, ALUOut 0x10..0x14.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drv = mk(32'h10 + i, 4'(i), 1'b0, 1'b0, 1'b1);
      step(a);
      chk("stream_accept", a, 1'b1);
    end
    in_valid = 1'b0;
    idle(2);

    // Back-pressure: AA, BB accepted, CC held at the input.
    out_ready = 1'b0;
    send(mk(32'hAA, 4'd1, 1'b1, 1'b0, 1'b1), 3);
    send(mk(32'hBB, 4'd2, 1'b0, 1'b0, 1'b1), 3);
    drv      = mk(32'hCC, 4'd3, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    idle(2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_AA", ALUOutW, 32'hAA);
    out_ready = 1'b1;
    send(mk(32'hCC, 4'd3, 1'b0, 1'b1, 1'b0), 5);
    idle(3);

    // Flush while FULL, with a beat offered in the flush cycle.
    out_ready = 1'b0;
    send(mk(32'h51, 4'd5, 1'b0, 1'b0, 1'b1), 3);
    send(mk(32'h52, 4'd6, 1'b0, 1'b0, 1'b1), 3);
    idle(4);
    flush    = 1'b1;
    drv      = mk(32'h53, 4'd7, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    step(a);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_RegWriteW", RegWriteW, 0);
    chk("flush_in_ready",  in_ready,  1);
    out_ready = 1'b1;
    idle(3);

    // Bubble gating after a RegWrite+PCSrc beat leaves.
    send(mk(32'h61, 4'd9, 1'b1, 1'b1, 1'b1), 3);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      step(a);
      chk("bubble_gate", {RegWriteW, PCSrcW, MemtoRegW}, 3'b000);
    end

    // Forwarding match.
    out_ready = 1'b0;
    send(mk(32'h71, 4'd7, 1'b0, 1'b0, 1'b1), 3);
    fwd_addr = 4'd7;
    #1;
    chk("fwd_hit_7", fwd_hit, 1);
    fwd_addr = 4'd6;
    #1;
    chk("fwd_miss_6", fwd_hit, 0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    send(mk(32'h72, 4'd7, 1'b0, 1'b0, 1'b0), 3);
    fwd_addr = 4'd7;
    #1;
    chk("fwd_no_regwrite", fwd_hit, 0);
    out_ready = 1'b1;
    idle(2);

    // Random traffic, including occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      drv       = mk($urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drv.ReadData = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      fwd_addr  = 4'($urandom);
      step(a);
    end
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mw_elastic.md
Name: pipe_mw_elastic

Overview:
- Parametrised successor to the MEM->WB pipeline register of the pipelined core.
- Replaces the free-running register with an elastic two-entry stage: valid/ready handshake on both sides, synchronous flush, and control bits gated by validity.
- Adds a writeback forwarding-match output.
- Sits between the memory stage and register-file writeback; lets WB back-pressure MEM without losing a beat.

Parameters:
- DATA_W, 32, width of read-data and ALU-result fields
- ADDR_W, 4, width of destination register address (WA3)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (sync)
- in_valid  in  1  MEM stage presents a beat
- in_ready  out  1  stage can accept a beat this cycle
- RDM  in  DATA_W  memory read data
- ALUOutM  in  DATA_W  ALU result
- WA3M  in  ADDR_W  destination register
- MemtoRegM, PCSrcM, RegWriteM  in  1 each  control bits
- out_valid  out  1  WB beat present
- out_ready  in  1  WB consumes beat
- ReadDataW, ALUOutW  out  DATA_W  head-entry data
- WA3W  out  ADDR_W  head-entry destination
- MemtoRegW, PCSrcW, RegWriteW  out  1 each  head-entry control, forced 0 when out_valid=0
- fwd_addr  in  ADDR_W  source register queried by earlier stage
- fwd_hit  out  1  out_valid & RegWriteW & (WA3W==fwd_addr), combinational

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage: head entry (drives outputs) plus skid entry, each with its own valid bit.
- Occupancy states:
  - EMPTY (0)
  - ONE (head valid)
  - FULL (head+skid valid)
- in_ready = !skid_valid & !reset. It depends on registered state only, never on out_ready.
- accept = in_valid & in_ready; pop = out_valid & out_ready; out_valid = head_valid.
- Transitions, evaluated at posedge:
  - EMPTY + accept -> ONE; beat loaded into head.
  - ONE + accept & !pop -> FULL; beat loaded into skid.
  - ONE + accept & pop -> ONE; beat loaded into head (pass-through, zero bubble).
  - ONE + pop & !accept -> EMPTY.
  - FULL + pop -> ONE; skid moves to head. No accept is possible while FULL.
  - Otherwise hold. Head contents never change while out_valid & !out_ready.
- Latency: 1 cycle from accept to out_valid when empty. Full throughput of 1 beat/cycle when out_ready is held high.
- Flush: next state EMPTY regardless of accept/pop in the same cycle. A beat accepted in the flush cycle is dropped. Flush has priority over everything except reset.
- Reset: head_valid=0, skid_valid=0, all data/address registers 0, all W control outputs 0, in_ready=0 while reset=1, in_ready=1 the cycle after reset deasserts. Reset mid-transfer discards all entries.
- Gating:
  - MemtoRegW, PCSrcW and RegWriteW are ANDed with out_valid, so a bubble never writes the register file or redirects the PC.
  - ReadDataW, ALUOutW and WA3W show stale head contents when invalid; consumers must qualify them with out_valid.
- Widths: all data is passed through unmodified; no arithmetic.

Optional Feature:
- Macro PIPE_MW_PERF_EN.
- When defined:
  - Adds outputs stall_cnt and bubble_cnt (32 bits each).
  - stall_cnt increments on every cycle with out_valid & !out_ready.
  - bubble_cnt increments on every cycle with !out_valid.
  - Both counters saturate at all-ones, clear on reset, and are unaffected by flush.
- When undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef mw_ctrl_t, a packed struct {MemtoReg, PCSrc, RegWrite}
  - typedef mw_beat_t, a packed struct {ReadData, ALUOut, WA3, ctrl}, parametrised via package localparams DATA_W_DEF=32 and ADDR_W_DEF=4
  - occupancy enum {EMPTY, ONE, FULL}
- One natural sub-module: skid_buf2, a generic two-entry valid/ready buffer over a packed beat of parametrised width with a flush input. pipe_mw_elastic instantiates it and adds control gating, fwd_hit and the optional counters.

Test Plan:
- Reset then stream: hold reset 2 cycles, then in_valid=1 with out_ready=1, ALUOutM=0x10..0x14, 5 beats -> out_valid rises 1 cycle after first accept; ALUOutW reads 0x10..0x14 on consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0 while 3 beats are offered (A=0xAA, B=0xBB, C=0xCC) -> A and B accepted, in_ready=0 after B, C held at input; head stays 0xAA. Raising out_ready then delivers AA, BB, CC in order, with no loss or duplication.
- Flush: FULL with RegWriteM=1 beats; assert flush together with in_valid=1 -> next cycle out_valid=0, RegWriteW=0, in_ready=1; the flushed-cycle beat never appears.
- Bubble gating: in_valid=0 for 3 cycles after a beat with RegWriteM=1, PCSrcM=1 is popped -> RegWriteW=PCSrcW=MemtoRegW=0 during the bubbles.
- Forwarding: head WA3W=4'd7, RegWriteW=1, out_valid=1; fwd_addr=7 gives fwd_hit=1; fwd_addr=6 gives 0; with RegWriteM=0 on the head beat, fwd_hit=0.
- With PIPE_MW_PERF_EN: 4 back-pressured cycles and 3 empty cycles -> stall_cnt=4, bubble_cnt=3 (counts since reset). Counters are unchanged across a flush and read 0 after reset.
